// File: rtl/fifo_wptr_prog.sv
// Write-side pointer and flag generator for async FIFOs with run-time power-of-two depth.
// Consumes the two-flop synchronised Gray read pointer; all logic is in the write clock domain.
module fifo_wptr_prog #(
    parameter int unsigned ADDR_FIFO = 4,
    parameter int unsigned CFG_W     = 3
) (
    input  logic                 W_CLK,
    input  logic                 W_rst_n,
    input  logic                 W_clr,
    input  logic [CFG_W-1:0]     cfg_depth_log2,
    input  logic [ADDR_FIFO:0]   cfg_afull_thr,
    input  logic                 W_inc,
    input  logic [ADDR_FIFO:0]   Wq2_rptr,
    input  logic                 ovf_clr,
    output logic                 W_Wen,
    output logic [ADDR_FIFO-1:0] W_Addr,
    output logic [ADDR_FIFO:0]   W_ptr,
    output logic                 W_Full,
    output logic                 W_AFull,
    output logic [ADDR_FIFO:0]   W_Level,
    output logic                 W_Ovf
);

    localparam int unsigned PW = ADDR_FIFO + 1;

    logic [ADDR_FIFO:0]   r_wbin;
    logic [CFG_W-1:0]     r_k;
    logic                 r_ovf;

    logic [ADDR_FIFO:0]   w_mask;
    logic [ADDR_FIFO:0]   w_depth;
    logic [ADDR_FIFO-1:0] w_amask;
    logic [ADDR_FIFO:0]   w_rbin_raw;
    logic [ADDR_FIFO:0]   w_rbin;
    logic [ADDR_FIFO:0]   w_level;
    logic [ADDR_FIFO:0]   w_wbin_inc;
    logic [CFG_W-1:0]     w_k_load;
    logic                 w_full;
    logic                 w_wen;

    // Masks derived from k: pointer span (k+1 bits), depth value 2^k, address span (k bits).
    always_comb begin
        w_mask  = '0;
        w_depth = '0;
        w_amask = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_mask[i]  = (CFG_W'(i) <= r_k);
            w_depth[i] = (CFG_W'(i) == r_k);
        end
        for (int i = 0; i < int'(ADDR_FIFO); i++) begin
            w_amask[i] = (CFG_W'(i) < r_k);
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin_raw = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_rbin_raw[i] = ^(Wq2_rptr >> i);
        end
    end

    assign w_rbin     = w_rbin_raw & w_mask;
    assign w_level    = (r_wbin - w_rbin) & w_mask;
    assign w_full     = (w_level == w_depth);
    assign w_wen      = W_inc & ~w_full & ~W_clr;
    assign w_wbin_inc = (r_wbin + PW'(1)) & w_mask;

    // Out-of-range depth requests fall back to the physical depth.
    assign w_k_load = ((cfg_depth_log2 == '0) || (cfg_depth_log2 > CFG_W'(ADDR_FIFO)))
                      ? CFG_W'(ADDR_FIFO) : cfg_depth_log2;

    always_ff @(posedge W_CLK or negedge W_rst_n) begin
        if (!W_rst_n) begin
            r_wbin <= '0;
            r_k    <= CFG_W'(ADDR_FIFO);
            r_ovf  <= 1'b0;
        end else if (W_clr) begin
            r_wbin <= '0;
            r_k    <= w_k_load;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wen) begin
                r_wbin <= w_wbin_inc;
            end
            // Overflow set takes priority over a concurrent clear request.
            if (W_inc && w_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign W_Wen   = w_wen;
    assign W_Addr  = r_wbin[ADDR_FIFO-1:0] & w_amask;
    assign W_ptr   = (r_wbin >> 1) ^ r_wbin;
    assign W_Full  = w_full;
    assign W_AFull = (cfg_afull_thr != '0) && (w_level >= cfg_afull_thr);
    assign W_Level = w_level;
    assign W_Ovf   = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_prog.sv
// Self-checking bench for fifo_wptr_prog: directed scenarios plus randomized traffic,
// compared every falling edge against an arithmetic model of the pointer/flag rules.
module tb_fifo_wptr_prog;

    localparam int AF = 4;
    localparam int PW = AF + 1;

    logic          W_CLK = 1'b0;
    logic          W_rst_n;
    logic          W_clr;
    logic [2:0]    cfg_depth_log2;
    logic [AF:0]   cfg_afull_thr;
    logic          W_inc;
    logic [AF:0]   Wq2_rptr;
    logic          ovf_clr;
    logic          W_Wen;
    logic [AF-1:0] W_Addr;
    logic [AF:0]   W_ptr;
    logic          W_Full;
    logic          W_AFull;
    logic [AF:0]   W_Level;
    logic          W_Ovf;

    int checks = 0;
    int errors = 0;
    int rb     = 0;

    int m_wbin = 0;
    int m_k    = AF;
    int m_ovf  = 0;

    always #5 W_CLK = ~W_CLK;

    assign Wq2_rptr = PW'(rb ^ (rb >> 1));

    fifo_wptr_prog #(.ADDR_FIFO(AF), .CFG_W(3)) dut (
        .W_CLK          (W_CLK),
        .W_rst_n        (W_rst_n),
        .W_clr          (W_clr),
        .cfg_depth_log2 (cfg_depth_log2),
        .cfg_afull_thr  (cfg_afull_thr),
        .W_inc          (W_inc),
        .Wq2_rptr       (Wq2_rptr),
        .ovf_clr        (ovf_clr),
        .W_Wen          (W_Wen),
        .W_Addr         (W_Addr),
        .W_ptr          (W_ptr),
        .W_Full         (W_Full),
        .W_AFull        (W_AFull),
        .W_Level        (W_Level),
        .W_Ovf          (W_Ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = g;
        for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    function automatic int e_level();
        int md = 2 << m_k;
        int r  = g2b(int'(Wq2_rptr)) % md;
        return (m_wbin - r + md) % md;
    endfunction

    function automatic int e_full();
        return (e_level() == (1 << m_k)) ? 1 : 0;
    endfunction

    always @(posedge W_CLK or negedge W_rst_n) begin
        if (!W_rst_n) begin
            m_wbin <= 0;
            m_k    <= AF;
            m_ovf  <= 0;
        end else if (W_clr) begin
            m_k    <= (cfg_depth_log2 == 0 || int'(cfg_depth_log2) > AF) ? AF
                      : int'(cfg_depth_log2);
            m_wbin <= 0;
            m_ovf  <= 0;
        end else begin
            if (W_inc && e_full() == 0) m_wbin <= (m_wbin + 1) % (2 << m_k);
            if (W_inc && e_full() == 1) m_ovf <= 1;
            else if (ovf_clr) m_ovf <= 0;
        end
    end

    always @(negedge W_CLK) begin
        int lv;
        lv = e_level();
        chk("m_level", int'(W_Level), lv);
        chk("m_full", int'(W_Full), e_full());
        chk("m_afull", int'(W_AFull), (cfg_afull_thr != 0 && lv >= int'(cfg_afull_thr)) ? 1 : 0);
        chk("m_wen", int'(W_Wen), (W_inc && e_full() == 0 && !W_clr) ? 1 : 0);
        chk("m_addr", int'(W_Addr), m_wbin % (1 << m_k));
        chk("m_ptr", int'(W_ptr), m_wbin ^ (m_wbin >> 1));
        chk("m_ovf", int'(W_Ovf), m_ovf);
    end

    task automatic tick();
        @(posedge W_CLK);
        #2;
    endtask

    initial begin
        int n;
        int wraps;
        int a_prev;
        int p_prev;
        logic [AF:0] pv;

        W_rst_n = 1'b0;
        W_clr = 1'b0;
        cfg_depth_log2 = 3'd4;
        cfg_afull_thr = '0;
        W_inc = 1'b0;
        ovf_clr = 1'b0;
        rb = 0;
        #12;
        chk("rst_ptr", int'(W_ptr), 0);
        chk("rst_addr", int'(W_Addr), 0);
        chk("rst_level", int'(W_Level), 0);
        chk("rst_full", int'(W_Full), 0);
        chk("rst_wen", int'(W_Wen), 0);
        chk("rst_ovf", int'(W_Ovf), 0);
        W_rst_n = 1'b1;

        // Fill to full at depth 16.
        W_inc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1 chk("fill_addr", int'(W_Addr), i);
            tick();
        end
        #1;
        chk("fill_full", int'(W_Full), 1);
        chk("fill_level", int'(W_Level), 16);
        chk("fill_ptr", int'(W_ptr), 24);

        // Overflow behaviour.
        chk("ovf_wen", int'(W_Wen), 0);
        tick();
        #1;
        chk("ovf_set", int'(W_Ovf), 1);
        chk("ovf_addr_hold", int'(W_Addr), 0);
        chk("ovf_level_hold", int'(W_Level), 16);
        ovf_clr = 1'b1;
        tick();
        #1 chk("ovf_set_wins", int'(W_Ovf), 1);
        W_inc = 1'b0;
        tick();
        #1 chk("ovf_cleared", int'(W_Ovf), 0);
        ovf_clr = 1'b0;

        // Depth 4.
        W_clr = 1'b1;
        cfg_depth_log2 = 3'd2;
        tick();
        W_clr = 1'b0;
        W_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("d4_addr", int'(W_Addr), i);
            tick();
        end
        W_inc = 1'b0;
        #1;
        chk("d4_full", int'(W_Full), 1);
        chk("d4_ptr", int'(W_ptr), 6);
        rb = 4;
        #1;
        chk("d4_level_empty", int'(W_Level), 0);
        chk("d4_full_clear", int'(W_Full), 0);
        W_inc = 1'b1;
        #1;
        chk("d4_wrap_wen", int'(W_Wen), 1);
        chk("d4_wrap_addr", int'(W_Addr), 0);
        tick();
        W_inc = 1'b0;

        // Almost-full at threshold 12.
        W_clr = 1'b1;
        cfg_depth_log2 = 3'd4;
        cfg_afull_thr = 5'd12;
        rb = 0;
        tick();
        W_clr = 1'b0;
        W_inc = 1'b1;
        repeat (12) tick();
        W_inc = 1'b0;
        #1;
        chk("af_set", int'(W_AFull), 1);
        chk("af_level", int'(W_Level), 12);
        rb = 1;
        #1;
        chk("af_level_rd", int'(W_Level), 11);
        chk("af_clear", int'(W_AFull), 0);

        // Clear colliding with a write, then asynchronous reset mid-cycle.
        W_inc = 1'b1;
        repeat (3) tick();
        W_clr = 1'b1;
        #1 chk("clr_inc_wen", int'(W_Wen), 0);
        tick();
        W_clr = 1'b0;
        rb = 0;
        #1;
        chk("clr_addr", int'(W_Addr), 0);
        chk("clr_ptr", int'(W_ptr), 0);
        W_clr = 1'b1;
        cfg_depth_log2 = 3'd2;
        W_inc = 1'b0;
        tick();
        W_clr = 1'b0;
        W_inc = 1'b1;
        repeat (3) tick();
        W_inc = 1'b0;
        W_rst_n = 1'b0;
        #1;
        chk("arst_addr", int'(W_Addr), 0);
        chk("arst_ptr", int'(W_ptr), 0);
        chk("arst_level", int'(W_Level), 0);
        chk("arst_full", int'(W_Full), 0);
        chk("arst_afull", int'(W_AFull), 0);
        chk("arst_wen", int'(W_Wen), 0);
        chk("arst_ovf", int'(W_Ovf), 0);
        @(negedge W_CLK);
        #2 W_rst_n = 1'b1;
        W_inc = 1'b1;
        repeat (4) tick();
        W_inc = 1'b0;
        #1;
        chk("arst_k_full", int'(W_Full), 0);
        chk("arst_k_level", int'(W_Level), 4);

        // Depth 8 streaming with reader two behind.
        W_clr = 1'b1;
        cfg_depth_log2 = 3'd3;
        cfg_afull_thr = '0;
        rb = 0;
        tick();
        W_clr = 1'b0;
        W_inc = 1'b1;
        n = 0;
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            a_prev = int'(W_Addr);
            p_prev = int'(W_ptr);
            chk("s8_wen", int'(W_Wen), 1);
            tick();
            n++;
            rb = (n >= 2) ? (n - 2) % 16 : 0;
            #1;
            pv = W_ptr ^ PW'(p_prev);
            chk("s8_gray_step", $countones(pv), 1);
            chk("s8_ptr_msb", int'(W_ptr[4]), 0);
            chk("s8_full", int'(W_Full), 0);
            if (a_prev == 7 && int'(W_Addr) == 0) wraps++;
        end
        chk("s8_wraps", wraps, 5);
        W_inc = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            int clr_now;
            clr_now = ($urandom_range(0, 39) == 0) ? 1 : 0;
            W_clr = clr_now[0];
            cfg_depth_log2 = 3'($urandom_range(0, 7));
            W_inc = ($urandom_range(0, 9) < 7);
            ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) cfg_afull_thr = 5'($urandom_range(0, 16));
            tick();
            if (clr_now == 1) rb = 0;
            else if (e_level() > 0 && $urandom_range(0, 9) < 4) rb = (rb + 1) % (2 << m_k);
        end
        W_inc = 1'b0;
        W_clr = 1'b0;
        ovf_clr = 1'b0;
        @(negedge W_CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_prog.md
Name: fifo_wptr_prog

Overview:
Write-side pointer and flag generator for the asynchronous FIFOs in the PHY/peripheral data paths. It supersedes the fixed-depth write pointer. It adds:
- run-time programmable power-of-two depth, configured through a soft clear;
- an occupancy level output and a programmable almost-full flag;
- a sticky overflow flag;
- an explicit memory write enable.

It runs entirely in the write clock domain. It consumes the read pointer after that pointer has been Gray-coded and two-flop synchronised.

Parameters:
ADDR_FIFO, 4, log2 of the physical FIFO depth (max depth = 2^ADDR_FIFO).
CFG_W, 3, width of cfg_depth_log2. Must satisfy 2^CFG_W > ADDR_FIFO.

Ports:
W_CLK  in  1  write clock.
W_rst_n  in  1  asynchronous active-low reset.
W_clr  in  1  synchronous soft clear; also loads the depth configuration.
cfg_depth_log2  in  CFG_W  requested depth exponent k; sampled only when W_clr=1.
cfg_afull_thr  in  ADDR_FIFO+1  almost-full threshold in entries; 0 disables W_AFull.
W_inc  in  1  write request.
Wq2_rptr  in  ADDR_FIFO+1  synchronised Gray read pointer.
ovf_clr  in  1  clears W_Ovf.
W_Wen  out  1  memory write enable.
W_Addr  out  ADDR_FIFO  binary memory write address.
W_ptr  out  ADDR_FIFO+1  Gray write pointer, sent to the read domain.
W_Full  out  1  FIFO full.
W_AFull  out  1  level >= cfg_afull_thr.
W_Level  out  ADDR_FIFO+1  entries currently occupied, as seen from the write side.
W_Ovf  out  1  sticky overflow.

Behaviour:
- State registers:
  - wbin: ADDR_FIFO+1-bit binary pointer.
  - k: active depth exponent, CFG_W bits.
  - ovf: sticky overflow bit.
- Reset (W_rst_n=0, asynchronous): wbin=0, k=ADDR_FIFO, ovf=0.
- Output values during reset, with Wq2_rptr=0: W_ptr=0, W_Addr=0, W_Level=0, W_Full=0, W_AFull=0 (or 1 if thr=0 is not the case and thr<=0, i.e. never), W_Wen=0, W_Ovf=0.
- Depth load: on a clock edge with W_clr=1, k <= cfg_depth_log2. Values 0 or > ADDR_FIFO clamp to ADDR_FIFO. On the same edge wbin <= 0 and ovf <= 0.
- The read side must be cleared with the same k. Changing k by any other means is illegal.
- Masking:
  - M = 2^(k+1)-1.
  - wbin only ever holds values <= M; bits above position k stay 0.
  - rbin = Gray-to-binary(Wq2_rptr) & M.
- Increment: W_Wen = W_inc & ~W_Full & ~W_clr. On an edge with W_Wen=1, wbin <= (wbin+1) & M. Wrap-around is the natural roll-over; the wrap bit is bit k.
- W_Addr = wbin & (2^k - 1), zero-extended to ADDR_FIFO bits.
- W_ptr = (wbin>>1) ^ wbin. Exactly one bit changes per increment, including across the wrap. Bits above k are 0.
- W_Level = (wbin - rbin) & M, computed in ADDR_FIFO+1 bits.
- W_Full = (W_Level == 2^k).
- W_AFull = (cfg_afull_thr != 0) & (W_Level >= cfg_afull_thr).
- Flag timing: all flags are combinational from registered wbin and from Wq2_rptr.
  - A write accepted on edge n is reflected in the flags from edge n onward, with zero added latency.
  - A change on Wq2_rptr is reflected in the same cycle.
- Overflow:
  - On an edge with W_inc=1, W_Full=1 and W_clr=0, ovf <= 1. wbin is unchanged and W_Wen=0.
  - ovf_clr=1 clears ovf.
  - If set and clear occur in the same cycle, set wins.
  - W_clr clears ovf.
- Simultaneous W_clr and W_inc: clear wins and the write is dropped.
- Reset asserted mid-stream: outputs return to reset values immediately, without waiting for a clock.

Test Plan:
1. ADDR_FIFO=4, reset, Wq2_rptr=0, W_inc held for 16 cycles -> W_Addr steps 0..15. After the 16th write: W_Full=1, W_Level=16, W_ptr=5'b11000.
2. Continue from 1 with a 17th W_inc -> W_Wen=0, wbin unchanged, W_Ovf=1. Then ovf_clr=1 together with W_inc while full -> W_Ovf stays 1. Then ovf_clr alone -> W_Ovf=0.
3. W_clr with cfg_depth_log2=2, then 4 writes -> W_Addr 0,1,2,3, W_Full=1, W_ptr=5'b00110. Set Wq2_rptr=5'b00110 -> W_Level=0, W_Full=0. Next write -> W_Addr=0.
4. Depth 16, cfg_afull_thr=12, 12 writes -> W_AFull=1, W_Level=12. Then Wq2_rptr=5'b00001 -> W_Level=11, W_AFull=0.
5. W_clr and W_inc in the same cycle mid-stream -> W_Wen=0, W_Addr=0, W_ptr=0. Async W_rst_n pulse between clock edges -> all outputs return to 0 and k=4 before the next edge.
6. Depth 8 (k=3), 40 writes with the read pointer tracking two writes behind -> W_ptr differs by exactly one bit per accepted write, bits [4] always 0, W_Addr wraps 7->0, W_Full never asserts.
